// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic multiplier result path.
package systolic_pkg;

  localparam int unsigned DEF_RESULT_WIDTH = 16;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } drain_state_e;

  // Index width that stays legal for a single-entry dimension.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Result-capture and output-stream signals of the systolic result drain.
interface systolic_result_drain_if
  import systolic_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int unsigned M            = 8,
  parameter int unsigned P            = 8
);

  localparam int unsigned RowW = idx_w(M);
  localparam int unsigned ColW = idx_w(P);

  logic                          done_in;
  logic [M*P*RESULT_WIDTH-1:0]   result_c;
  logic                          busy;
  logic                          m_valid;
  logic                          m_ready;
  logic [RESULT_WIDTH-1:0]       m_data;
  logic [RowW-1:0]               m_row;
  logic [ColW-1:0]               m_col;
  logic                          m_last;
  logic                          overrun;

  // Drain side: sources the output stream.
  modport master (
    input  done_in, result_c, m_ready,
    output busy, m_valid, m_data, m_row, m_col, m_last, overrun
  );

  // Environment side: multiplier plus stream sink.
  modport slave (
    output done_in, result_c, m_ready,
    input  busy, m_valid, m_data, m_row, m_col, m_last, overrun
  );

endinterface

// File: rtl/systolic_rc_counter.sv
// Two-level row/col wrap counter; SMM_DRAIN_TRANSPOSE_EN makes row the inner index.
module systolic_rc_counter
  import systolic_pkg::*;
#(
  parameter int unsigned Rows = 8,
  parameter int unsigned Cols = 8,
  localparam int unsigned RowW = idx_w(Rows),
  localparam int unsigned ColW = idx_w(Cols)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  output logic [RowW-1:0] row,
  output logic [ColW-1:0] col,
  output logic            last
);

  localparam logic [RowW-1:0] RowMax = RowW'(Rows - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(Cols - 1);

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
`ifdef SMM_DRAIN_TRANSPOSE_EN
      if (row_q == RowMax) begin
        row_d = '0;
        col_d = (col_q == ColMax) ? '0 : col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
`else
      if (col_q == ColMax) begin
        col_d = '0;
        row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == RowMax) && (col_q == ColMax);

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the M x P result bus on done_in and streams it one element per beat.
// Build with SMM_DRAIN_TRANSPOSE_EN for column-major drain order.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int unsigned M            = 8,
  parameter int unsigned P            = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_result_drain_if.master bus
);

  localparam int unsigned RowW = idx_w(M);
  localparam int unsigned ColW = idx_w(P);
  localparam int unsigned BusW = M * P * RESULT_WIDTH;

  drain_state_e    state_q, state_d;
  logic [BusW-1:0] snap_q;
  logic            overrun_q, overrun_d;
  logic            capture, clear, advance;
  logic [RowW-1:0] row;
  logic [ColW-1:0] col;
  logic            cnt_last;
  int unsigned     elem_idx;

  systolic_rc_counter #(
    .Rows (M),
    .Cols (P)
  ) u_rc_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .row     (row),
    .col     (col),
    .last    (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    clear     = 1'b0;
    advance   = 1'b0;
    overrun_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.done_in) begin
          capture = 1'b1;
          clear   = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (bus.m_ready && cnt_last) begin
          // Final beat: a coincident done_in chains straight into the next snapshot.
          advance = 1'b1;
          if (bus.done_in) begin
            capture = 1'b1;
            clear   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          advance   = bus.m_ready;
          overrun_d = bus.done_in;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
      if (capture) begin
        snap_q <= bus.result_c;
      end
    end
  end

  always_comb begin
    elem_idx = 32'(row) * P + 32'(col);
  end

  assign bus.busy    = (state_q == StStream);
  assign bus.m_valid = (state_q == StStream);
  assign bus.m_last  = (state_q == StStream) && cnt_last;
  assign bus.m_data  = snap_q[elem_idx * RESULT_WIDTH +: RESULT_WIDTH];
  assign bus.m_row   = row;
  assign bus.m_col   = col;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed plus randomized check of systolic_result_drain against a beat-queue model.
module tb_systolic_result_drain;

  localparam int unsigned W    = 16;
  localparam int unsigned M    = 2;
  localparam int unsigned P    = 3;
  localparam int unsigned BusW = M * P * W;

  typedef struct {
    logic [W-1:0] d;
    int           r;
    int           c;
    bit           last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_result_drain_if #(.RESULT_WIDTH(W), .M(M), .P(P)) bus ();

  systolic_result_drain #(
    .RESULT_WIDTH (W),
    .M            (M),
    .P            (P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  beat_t pend[$];
  bit    exp_ovr     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat sequence for one snapshot, straight from the drain-order rule.
  task automatic load(input logic [BusW-1:0] res);
    beat_t b;
`ifdef SMM_DRAIN_TRANSPOSE_EN
    for (int c = 0; c < P; c++) begin
      for (int r = 0; r < M; r++) begin
`else
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < P; c++) begin
`endif
        b.d    = res[(r * P + c) * W +: W];
        b.r    = r;
        b.c    = c;
        b.last = (r == M - 1) && (c == P - 1);
        pend.push_back(b);
      end
    end
  endtask

  // Runs at a negedge: check outputs, drive inputs, predict, advance one cycle.
  task automatic cyc(input bit done, input logic [BusW-1:0] res, input bit ready);
    bit v;
    v = (pend.size() > 0);
    chk("busy", 32'(bus.busy), 32'(v));
    chk("m_valid", 32'(bus.m_valid), 32'(v));
    chk("m_last", 32'(bus.m_last), v ? 32'(pend[0].last) : 32'd0);
    chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
    if (v) begin
      chk("m_data", 32'(bus.m_data), 32'(pend[0].d));
      chk("m_row", 32'(bus.m_row), pend[0].r);
      chk("m_col", 32'(bus.m_col), pend[0].c);
    end
    bus.done_in  = done;
    bus.result_c = res;
    bus.m_ready  = ready;
    if (v && ready) void'(pend.pop_front());
    exp_ovr = 1'b0;
    if (done) begin
      if (pend.size() == 0) load(res);
      else exp_ovr = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.m_valid), 0);
    chk({tag, "_last"}, 32'(bus.m_last), 0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 0);
    chk({tag, "_data"}, 32'(bus.m_data), 0);
    chk({tag, "_row"}, 32'(bus.m_row), 0);
    chk({tag, "_col"}, 32'(bus.m_col), 0);
  endtask

  function automatic logic [BusW-1:0] rnd_bus();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [BusW-1:0] a, b;
    bus.done_in  = 1'b0;
    bus.result_c = '0;
    bus.m_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_check("reset");
    rst = 1'b0;
    cyc(0, '0, 1);

    // Basic row-major drain at full rate.
    a = {16'hFFFF, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    cyc(1, a, 1);
    for (int i = 0; i < M * P + 2; i++) cyc(0, '0, 1);

    // Backpressure: ready pattern 1,0,0,1,...
    b = {16'h8000, 16'h7FFF, 16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0};
    cyc(1, b, 0);
    for (int i = 0; i < 4 * M * P; i++) cyc(0, '0, (i % 3) == 0);
    for (int i = 0; i < M * P; i++) cyc(0, '0, 1);

    // Overrun: done_in mid-stream is dropped.
    cyc(1, a, 1);
    cyc(0, '0, 1);
    cyc(1, b, 1);
    for (int i = 0; i < M * P + 1; i++) cyc(0, '0, 1);

    // Back-to-back: done_in on the final transfer.
    cyc(1, a, 1);
    for (int i = 0; i < 16 && pend.size() > 1; i++) cyc(0, '0, 1);
    b = {16'h0060, 16'h0050, 16'h0040, 16'h0030, 16'h0020, 16'h0010};
    cyc(1, b, 1);
    for (int i = 0; i < M * P + 1; i++) cyc(0, '0, 1);

    // Reset mid-stream after one beat, then restart.
    cyc(1, a, 1);
    cyc(0, '0, 1);
    rst = 1'b1;
    #1;
    reset_check("midrst");
    pend.delete();
    exp_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, '0, 1);
    cyc(1, b, 1);
    for (int i = 0; i < M * P + 1; i++) cyc(0, '0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 7) == 0, rnd_bus(), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 2 * M * P; i++) cyc(0, '0, 1);
    chk("drained", 32'(pend.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
